// File: rtl/rf_read_stage.sv
// rtl/rf_read_stage.sv - register-read stage: busy scoreboard check, regfile read-port arbitration,
// FU operand delivery and issue-queue dequeue/replay feedback one cycle after issue.
module rf_read_stage #(
  parameter int PORT_NUM   = 2,
  parameter int IQ_DEPTH   = 8,
  parameter int PREG_NUM   = 64,
  parameter int RFREAD_NUM = 3,
  parameter int WBPORT_NUM = 6,
  parameter int ALLOC_NUM  = 2,
  parameter int XLEN       = 64,
  parameter int UOP_W      = 16,
  localparam int IW = $clog2(IQ_DEPTH),
  localparam int PW = $clog2(PREG_NUM)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [PORT_NUM-1:0]                   i_iss_vld,
  input  logic [PORT_NUM-1:0][IW-1:0]           i_iss_idx,
  input  logic [PORT_NUM-1:0][PW-1:0]           i_iss_rs1,
  input  logic [PORT_NUM-1:0][PW-1:0]           i_iss_rs2,
  input  logic [PORT_NUM-1:0][1:0]              i_iss_use,
  input  logic [PORT_NUM-1:0][PW-1:0]           i_iss_rd,
  input  logic [PORT_NUM-1:0]                   i_iss_rd_wen,
  input  logic [PORT_NUM-1:0][UOP_W-1:0]        i_iss_uop,
  input  logic [PORT_NUM-1:0]                   i_fu_ready,
  input  logic                                  i_flush,
  input  logic [ALLOC_NUM-1:0]                  i_alloc_vld,
  input  logic [ALLOC_NUM-1:0][PW-1:0]          i_alloc_rd,
  input  logic [WBPORT_NUM-1:0]                 i_wb_vld,
  input  logic [WBPORT_NUM-1:0][PW-1:0]         i_wb_rd,
  input  logic [WBPORT_NUM-1:0][XLEN-1:0]       i_wb_data,
  output logic [RFREAD_NUM-1:0]                 o_rf_ren,
  output logic [RFREAD_NUM-1:0][PW-1:0]         o_rf_raddr,
  input  logic [RFREAD_NUM-1:0][XLEN-1:0]       i_rf_rdata,
  output logic [PORT_NUM-1:0][IW-1:0]           o_fb_idx,
  output logic [PORT_NUM-1:0]                   o_deq_vld,
  output logic [PORT_NUM-1:0]                   o_replay_vld,
  output logic [PORT_NUM-1:0]                   o_fu_vld,
  output logic [PORT_NUM-1:0][UOP_W-1:0]        o_fu_uop,
  output logic [PORT_NUM-1:0][PW-1:0]           o_fu_rd,
  output logic [PORT_NUM-1:0]                   o_fu_rd_wen,
  output logic [PORT_NUM-1:0][XLEN-1:0]         o_fu_src1,
  output logic [PORT_NUM-1:0][XLEN-1:0]         o_fu_src2,
  output logic [15:0]                           o_replay_cnt
);

  localparam int RW = (RFREAD_NUM > 1) ? $clog2(RFREAD_NUM) : 1;

  logic [PREG_NUM-1:0]                 busy;
  logic [PREG_NUM-1:0]                 busy_nxt;
  logic [PORT_NUM-1:0][1:0][PW-1:0]    src_preg;
  logic [PORT_NUM-1:0][1:0]            src_hit;
  logic [PORT_NUM-1:0][1:0]            src_need;
  logic [PORT_NUM-1:0][1:0]            src_rdy;
  logic [PORT_NUM-1:0][1:0][XLEN-1:0]  src_byp;
  logic [PORT_NUM-1:0][1:0][RW-1:0]    src_sel;
  logic [PORT_NUM-1:0]                 accept;
  logic [PORT_NUM-1:0]                 replay;
  logic [RFREAD_NUM-1:0]               rf_ren;
  logic [RFREAD_NUM-1:0][PW-1:0]       rf_raddr;
  logic [7:0]                          n_replay;
  logic [16:0]                         cnt_sum;

  logic [PORT_NUM-1:0][1:0]            use_rf_q;
  logic [PORT_NUM-1:0][1:0][RW-1:0]    sel_q;
  logic [PORT_NUM-1:0][1:0][XLEN-1:0]  byp_q;

  always_comb begin
    src_preg = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      src_preg[p][0] = i_iss_rs1[p];
      src_preg[p][1] = i_iss_rs2[p];
    end
  end

  // Bypass takes precedence over the scoreboard; the lowest-numbered writeback port supplies data.
  always_comb begin
    src_hit  = '0;
    src_need = '0;
    src_rdy  = '0;
    src_byp  = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int s = 0; s < 2; s++) begin
        for (int w = WBPORT_NUM - 1; w >= 0; w--) begin
          if (i_wb_vld[w] && (i_wb_rd[w] == src_preg[p][s])) begin
            src_hit[p][s] = 1'b1;
            src_byp[p][s] = i_wb_data[w];
          end
        end
        if (!i_iss_use[p][s]) begin
          src_hit[p][s] = 1'b0;
          src_byp[p][s] = '0;
        end
        src_rdy[p][s]  = !i_iss_use[p][s] || src_hit[p][s] || !busy[src_preg[p][s]];
        src_need[p][s] = i_iss_use[p][s] && !src_hit[p][s] && !busy[src_preg[p][s]];
      end
    end
  end

  // All-or-nothing read-port grants in port order; a port that does not fit leaves its ports to later ones.
  always_comb begin
    int used;
    int need;
    used     = 0;
    need     = 0;
    rf_ren   = '0;
    rf_raddr = '0;
    src_sel  = '0;
    accept   = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      need = int'(src_need[p][0]) + int'(src_need[p][1]);
      if (i_iss_vld[p] && (&src_rdy[p]) && i_fu_ready[p] && !i_flush &&
          (used + need <= RFREAD_NUM)) begin
        accept[p] = 1'b1;
        for (int s = 0; s < 2; s++) begin
          if (src_need[p][s]) begin
            rf_ren[used]   = 1'b1;
            rf_raddr[used] = src_preg[p][s];
            src_sel[p][s]  = RW'(used);
            used           = used + 1;
          end
        end
      end
    end
    replay = i_iss_vld & ~accept & {PORT_NUM{!i_flush}};
  end

  always_comb begin
    n_replay = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      n_replay = n_replay + 8'(replay[p]);
    end
    cnt_sum = {1'b0, o_replay_cnt} + {9'b0, n_replay};
  end

  // Alloc is applied after wb so it wins on a same-cycle collision.
  always_comb begin
    busy_nxt = busy;
    for (int w = 0; w < WBPORT_NUM; w++) begin
      if (i_wb_vld[w]) busy_nxt[i_wb_rd[w]] = 1'b0;
    end
    for (int a = 0; a < ALLOC_NUM; a++) begin
      if (i_alloc_vld[a]) busy_nxt[i_alloc_rd[a]] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  assign o_rf_ren   = rst ? '0 : rf_ren;
  assign o_rf_raddr = rst ? '0 : rf_raddr;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy         <= '0;
      o_fb_idx     <= '0;
      o_deq_vld    <= '0;
      o_replay_vld <= '0;
      o_fu_vld     <= '0;
      o_fu_uop     <= '0;
      o_fu_rd      <= '0;
      o_fu_rd_wen  <= '0;
      use_rf_q     <= '0;
      sel_q        <= '0;
      byp_q        <= '0;
      o_replay_cnt <= '0;
    end else begin
      busy         <= busy_nxt;
      o_fb_idx     <= i_iss_idx;
      o_deq_vld    <= accept;
      o_replay_vld <= replay;
      o_fu_vld     <= accept;
      o_fu_uop     <= i_iss_uop;
      o_fu_rd      <= i_iss_rd;
      o_fu_rd_wen  <= i_iss_rd_wen & accept;
      sel_q        <= src_sel;
      for (int p = 0; p < PORT_NUM; p++) begin
        for (int s = 0; s < 2; s++) begin
          use_rf_q[p][s] <= accept[p] && src_need[p][s];
          byp_q[p][s]    <= accept[p] ? src_byp[p][s] : '0;
        end
      end
      o_replay_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end

  always_comb begin
    o_fu_src1 = '0;
    o_fu_src2 = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      o_fu_src1[p] = use_rf_q[p][0] ? i_rf_rdata[sel_q[p][0]] : byp_q[p][0];
      o_fu_src2[p] = use_rf_q[p][1] ? i_rf_rdata[sel_q[p][1]] : byp_q[p][1];
    end
  end

endmodule

// File: tb/tb_rf_read_stage.sv
// tb/tb_rf_read_stage.sv - directed and randomized bench for rf_read_stage against a behavioural model.
module tb_rf_read_stage;
  localparam int PORT_NUM = 2, IQ_DEPTH = 8, PREG_NUM = 64, RFREAD_NUM = 3;
  localparam int WBPORT_NUM = 6, ALLOC_NUM = 2, XLEN = 64, UOP_W = 16;
  localparam int IW = 3, PW = 6;

  logic clk, rst;
  logic [PORT_NUM-1:0]             i_iss_vld;
  logic [PORT_NUM-1:0][IW-1:0]     i_iss_idx;
  logic [PORT_NUM-1:0][PW-1:0]     i_iss_rs1, i_iss_rs2, i_iss_rd;
  logic [PORT_NUM-1:0][1:0]        i_iss_use;
  logic [PORT_NUM-1:0]             i_iss_rd_wen;
  logic [PORT_NUM-1:0][UOP_W-1:0]  i_iss_uop;
  logic [PORT_NUM-1:0]             i_fu_ready;
  logic                            i_flush;
  logic [ALLOC_NUM-1:0]            i_alloc_vld;
  logic [ALLOC_NUM-1:0][PW-1:0]    i_alloc_rd;
  logic [WBPORT_NUM-1:0]           i_wb_vld;
  logic [WBPORT_NUM-1:0][PW-1:0]   i_wb_rd;
  logic [WBPORT_NUM-1:0][XLEN-1:0] i_wb_data;
  logic [RFREAD_NUM-1:0]           o_rf_ren;
  logic [RFREAD_NUM-1:0][PW-1:0]   o_rf_raddr;
  logic [RFREAD_NUM-1:0][XLEN-1:0] i_rf_rdata;
  logic [PORT_NUM-1:0][IW-1:0]     o_fb_idx;
  logic [PORT_NUM-1:0]             o_deq_vld, o_replay_vld, o_fu_vld, o_fu_rd_wen;
  logic [PORT_NUM-1:0][UOP_W-1:0]  o_fu_uop;
  logic [PORT_NUM-1:0][PW-1:0]     o_fu_rd;
  logic [PORT_NUM-1:0][XLEN-1:0]   o_fu_src1, o_fu_src2;
  logic [15:0]                     o_replay_cnt;

  rf_read_stage #(
    .PORT_NUM(PORT_NUM), .IQ_DEPTH(IQ_DEPTH), .PREG_NUM(PREG_NUM), .RFREAD_NUM(RFREAD_NUM),
    .WBPORT_NUM(WBPORT_NUM), .ALLOC_NUM(ALLOC_NUM), .XLEN(XLEN), .UOP_W(UOP_W)
  ) dut (
    .clk(clk), .rst(rst),
    .i_iss_vld(i_iss_vld), .i_iss_idx(i_iss_idx), .i_iss_rs1(i_iss_rs1), .i_iss_rs2(i_iss_rs2),
    .i_iss_use(i_iss_use), .i_iss_rd(i_iss_rd), .i_iss_rd_wen(i_iss_rd_wen), .i_iss_uop(i_iss_uop),
    .i_fu_ready(i_fu_ready), .i_flush(i_flush),
    .i_alloc_vld(i_alloc_vld), .i_alloc_rd(i_alloc_rd),
    .i_wb_vld(i_wb_vld), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
    .o_rf_ren(o_rf_ren), .o_rf_raddr(o_rf_raddr), .i_rf_rdata(i_rf_rdata),
    .o_fb_idx(o_fb_idx), .o_deq_vld(o_deq_vld), .o_replay_vld(o_replay_vld),
    .o_fu_vld(o_fu_vld), .o_fu_uop(o_fu_uop), .o_fu_rd(o_fu_rd), .o_fu_rd_wen(o_fu_rd_wen),
    .o_fu_src1(o_fu_src1), .o_fu_src2(o_fu_src2), .o_replay_cnt(o_replay_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit              busy_m [PREG_NUM];
  logic [XLEN-1:0] rf_mem [PREG_NUM];
  int              cnt_m;
  logic [PORT_NUM-1:0] e_acc, e_rep;
  logic [IW-1:0]    e_idx  [PORT_NUM];
  logic [UOP_W-1:0] e_uop  [PORT_NUM];
  logic [PW-1:0]    e_rd   [PORT_NUM];
  logic             e_wen  [PORT_NUM];
  logic [XLEN-1:0]  e_src1 [PORT_NUM];
  logic [XLEN-1:0]  e_src2 [PORT_NUM];
  int               e_ren_cnt;
  int               last_ren_cnt;
  logic [RFREAD_NUM-1:0]         prev_ren;
  logic [RFREAD_NUM-1:0][PW-1:0] prev_raddr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural view: a source is served by bypass, else by the regfile if not busy; ports take
  // read ports greedily in order, all-or-nothing.
  task automatic model_eval();
    int free;
    free = RFREAD_NUM;
    e_acc = '0;
    e_rep = '0;
    e_ren_cnt = 0;
    for (int p = 0; p < PORT_NUM; p++) begin
      logic [XLEN-1:0] op [2];
      bit rdy [2];
      int need;
      need = 0;
      for (int s = 0; s < 2; s++) begin
        logic [PW-1:0] rs;
        bit hit;
        logic [XLEN-1:0] data;
        rs = (s == 0) ? i_iss_rs1[p] : i_iss_rs2[p];
        hit = 0;
        data = '0;
        for (int w = 0; w < WBPORT_NUM; w++)
          if (!hit && i_wb_vld[w] && i_wb_rd[w] == rs) begin hit = 1; data = i_wb_data[w]; end
        if (!i_iss_use[p][s]) begin
          rdy[s] = 1; op[s] = '0;
        end else if (hit) begin
          rdy[s] = 1; op[s] = data;
        end else begin
          rdy[s] = !busy_m[rs]; op[s] = rf_mem[rs];
          if (!busy_m[rs]) need++;
        end
      end
      e_idx[p] = i_iss_idx[p];
      e_uop[p] = i_iss_uop[p];
      e_rd[p]  = i_iss_rd[p];
      e_wen[p] = i_iss_rd_wen[p];
      e_src1[p] = op[0];
      e_src2[p] = op[1];
      if (!rst && i_iss_vld[p] && !i_flush) begin
        if (rdy[0] && rdy[1] && i_fu_ready[p] && need <= free) begin
          e_acc[p] = 1'b1;
          free -= need;
          e_ren_cnt += need;
        end else begin
          e_rep[p] = 1'b1;
        end
      end
    end
  endtask

  task automatic model_update();
    if (rst) begin
      foreach (busy_m[i]) busy_m[i] = 0;
      cnt_m = 0;
    end else begin
      for (int w = 0; w < WBPORT_NUM; w++) if (i_wb_vld[w]) busy_m[i_wb_rd[w]] = 0;
      for (int a = 0; a < ALLOC_NUM; a++) if (i_alloc_vld[a]) busy_m[i_alloc_rd[a]] = 1;
      busy_m[0] = 0;
      cnt_m = cnt_m + $countones(e_rep);
      if (cnt_m > 65535) cnt_m = 65535;
    end
  endtask

  task automatic compare();
    chk("deq_vld", o_deq_vld, e_acc);
    chk("replay_vld", o_replay_vld, e_rep);
    chk("fu_vld", o_fu_vld, e_acc);
    chk("replay_cnt", o_replay_cnt, cnt_m);
    for (int p = 0; p < PORT_NUM; p++) begin
      if (e_acc[p]) begin
        chk("fb_idx_deq", o_fb_idx[p], e_idx[p]);
        chk("fu_uop", o_fu_uop[p], e_uop[p]);
        chk("fu_rd", o_fu_rd[p], e_rd[p]);
        chk("fu_rd_wen", o_fu_rd_wen[p], e_wen[p]);
        chk("fu_src1", o_fu_src1[p], e_src1[p]);
        chk("fu_src2", o_fu_src2[p], e_src2[p]);
      end
      if (e_rep[p]) chk("fb_idx_replay", o_fb_idx[p], e_idx[p]);
    end
  endtask

  // One cycle: inputs already driven by caller; returns with T+1 outputs settled.
  task automatic step();
    #1;
    model_eval();
    last_ren_cnt = $countones(o_rf_ren);
    chk("rf_ren_cnt", last_ren_cnt, e_ren_cnt);
    prev_ren   = o_rf_ren;
    prev_raddr = o_rf_raddr;
    model_update();
    @(posedge clk);
    #1;
    for (int k = 0; k < RFREAD_NUM; k++)
      i_rf_rdata[k] = prev_ren[k] ? rf_mem[prev_raddr[k]] : {$urandom, $urandom};
    #1;
    compare();
  endtask

  task automatic idle();
    i_iss_vld = '0; i_iss_idx = '0; i_iss_rs1 = '0; i_iss_rs2 = '0; i_iss_use = '0;
    i_iss_rd = '0; i_iss_rd_wen = '0; i_iss_uop = '0; i_fu_ready = '1; i_flush = 1'b0;
    i_alloc_vld = '0; i_alloc_rd = '0; i_wb_vld = '0; i_wb_rd = '0; i_wb_data = '0;
  endtask

  task automatic rand_inputs();
    for (int p = 0; p < PORT_NUM; p++) begin
      i_iss_vld[p]    = 1'($urandom);
      i_iss_idx[p]    = IW'($urandom);
      i_iss_rs1[p]    = PW'($urandom_range(0, 15));
      i_iss_rs2[p]    = PW'($urandom_range(0, 15));
      i_iss_use[p]    = 2'($urandom);
      i_iss_rd[p]     = PW'($urandom);
      i_iss_rd_wen[p] = 1'($urandom);
      i_iss_uop[p]    = UOP_W'($urandom);
      i_fu_ready[p]   = ($urandom % 8) != 0;
    end
    i_flush = ($urandom % 16) == 0;
    for (int a = 0; a < ALLOC_NUM; a++) begin
      i_alloc_vld[a] = ($urandom % 4) == 0;
      i_alloc_rd[a]  = PW'($urandom_range(0, 15));
    end
    for (int w = 0; w < WBPORT_NUM; w++) begin
      i_wb_vld[w]  = ($urandom % 3) == 0;
      i_wb_rd[w]   = PW'($urandom_range(0, 15));
      i_wb_data[w] = {$urandom, $urandom};
    end
  endtask

  initial begin
    foreach (rf_mem[i]) rf_mem[i] = {$urandom, $urandom};
    foreach (busy_m[i]) busy_m[i] = 0;
    cnt_m = 0;
    i_rf_rdata = '0;
    idle();
    rst = 1'b1;
    step();
    step();
    chk("reset_deq", o_deq_vld, 0);
    chk("reset_fu_vld", o_fu_vld, 0);
    chk("reset_cnt", o_replay_cnt, 0);
    chk("reset_ren", last_ren_cnt, 0);
    rst = 1'b0;
    idle();
    step();

    i_iss_vld = 2'b01; i_iss_idx[0] = 3'd3; i_iss_rs1[0] = 6'd7; i_iss_rs2[0] = 6'd9;
    i_iss_use[0] = 2'b11;
    step();
    chk("basic_ren", last_ren_cnt, 2);
    chk("basic_deq", o_deq_vld, 2'b01);
    chk("basic_idx", o_fb_idx[0], 3);
    chk("basic_src1", o_fu_src1[0], rf_mem[7]);
    chk("basic_src2", o_fu_src2[0], rf_mem[9]);

    idle(); i_alloc_vld = 2'b01; i_alloc_rd[0] = 6'd10;
    step();
    idle(); i_iss_vld = 2'b01; i_iss_idx[0] = 3'd5; i_iss_rs1[0] = 6'd10; i_iss_use[0] = 2'b01;
    step();
    chk("busy_replay", o_replay_vld, 2'b01);
    chk("busy_cnt", o_replay_cnt, 1);
    i_wb_vld = 6'b000001; i_wb_rd[0] = 6'd10; i_wb_data[0] = 64'hABCD;
    step();
    chk("bypass_deq", o_deq_vld, 2'b01);
    chk("bypass_src1", o_fu_src1[0], 64'hABCD);
    chk("bypass_ren", last_ren_cnt, 0);

    idle(); i_iss_vld = 2'b11;
    i_iss_rs1[0] = 6'd20; i_iss_rs2[0] = 6'd21; i_iss_use[0] = 2'b11;
    i_iss_rs1[1] = 6'd22; i_iss_rs2[1] = 6'd23; i_iss_use[1] = 2'b11;
    step();
    chk("arb_deq", o_deq_vld, 2'b01);
    chk("arb_replay", o_replay_vld, 2'b10);
    i_iss_use[1] = 2'b01;
    step();
    chk("arb_fit_deq", o_deq_vld, 2'b11);
    chk("arb_fit_src1", o_fu_src1[1], rf_mem[22]);

    i_iss_use[0] = 2'b01; i_fu_ready = 2'b10;
    step();
    chk("fu_bp_deq", o_deq_vld, 2'b10);
    chk("fu_bp_replay", o_replay_vld, 2'b01);

    i_fu_ready = 2'b11; i_flush = 1'b1;
    step();
    chk("flush_deq", o_deq_vld, 0);
    chk("flush_replay", o_replay_vld, 0);
    chk("flush_fu_vld", o_fu_vld, 0);
    chk("flush_cnt", o_replay_cnt, 3);

    idle(); i_alloc_vld = 2'b01; i_alloc_rd[0] = 6'd5; i_wb_vld = 6'b000001; i_wb_rd[0] = 6'd5;
    step();
    idle(); i_iss_vld = 2'b01; i_iss_rs1[0] = 6'd5; i_iss_use[0] = 2'b01;
    step();
    chk("alloc_wins", o_replay_vld, 2'b01);

    repeat (3000) begin
      rand_inputs();
      step();
    end

    rand_inputs(); i_iss_vld = 2'b11; rst = 1'b1;
    step();
    chk("midrst_deq", o_deq_vld, 0);
    chk("midrst_replay", o_replay_vld, 0);
    chk("midrst_fu_vld", o_fu_vld, 0);
    chk("midrst_cnt", o_replay_cnt, 0);
    chk("midrst_src1", o_fu_src1[0], 0);
    chk("midrst_ren", last_ren_cnt, 0);
    rst = 1'b0;

    idle(); i_iss_vld = 2'b11; i_fu_ready = 2'b00;
    repeat (35000) step();
    chk("sat_cnt", o_replay_cnt, 16'hFFFF);
    repeat (3) step();
    chk("sat_hold", o_replay_cnt, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
